// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared encodings for the MEM-stage load/store engine.
//               Contents: FUNCT3 load/store size codes, the FSM state
//               encodings, the latched load-control record and the
//               FUNCT3 decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

  // FUNCT3 access size/sign codes. Loads and stores share the size field.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Per-access information kept for the response phase.
  typedef struct packed {
    logic       is_load;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } load_ctrl_t;

  // True for the five defined FUNCT3 encodings.
  function automatic logic funct3_listed(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte-aligned address.
  function automatic logic funct3_misaligned(input logic [2:0] f3,
                                             input logic [1:0] addr_lo);
    case (f3)
      F3_LH, F3_LHU: return addr_lo[0];
      F3_LW:         return |addr_lo;
      default:       return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_align_ext.sv
`default_nettype none
// ============================================================================
// Module      : load_align_ext
// Description : Combinational load alignment and extension. Selects the
//               addressed byte/halfword from a 32-bit read word and sign- or
//               zero-extends it according to FUNCT3. Stateless, so it can be
//               reused behind a cache.
// Ports       : rdata   in  32  raw read word from memory
//               addr_lo in   2  byte offset within the word
//               funct3  in   3  load size/sign code
//               result  out 32  aligned, extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module load_align_ext
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    // Move the addressed lane down to bit 0; halfword offsets are even.
    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  result = {24'h000000, shifted[7:0]};
      F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  result = {16'h0000, shifted[15:0]};
      default: result = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store engine. Accepts an effective address,
//               store operand and access controls, runs one access at a time
//               on a req/ack data bus, stalls the pipeline while busy, and
//               returns extended load data. Misaligned/illegal accesses and
//               bus timeouts are reported with a one-cycle FAULT pulse.
// Ports       : CLK, RESETn                clock, async active-low reset
//               VALID, MEM_READ, MEM_WRITE access request and direction
//               FUNCT3, ALU_RESULT         size/sign code, byte address
//               STORE_DATA                 store operand
//               MEM_REQ/WE/ADDR/BE/WDATA   data bus request side
//               MEM_RDATA, MEM_ACK         data bus response side
//               BUSY                       pipeline stall
//               DONE, FAULT                completion / error pulses
//               LOAD_DATA                  extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,  // >= 1
  parameter int CNT_W          = 5    // 2**CNT_W > TIMEOUT_CYCLES
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        VALID,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ALU_RESULT,
  input  logic [31:0] STORE_DATA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_BE,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] LOAD_DATA,
  output logic        FAULT
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             fault_q;
  load_ctrl_t       ctrl;

  logic             access;
  logic             illegal;
  logic             legal_access;
  logic             illegal_access;
  logic             timeout;
  logic [3:0]       be_next;
  logic [31:0]      wdata_next;
  logic [31:0]      load_ext;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  assign access  = VALID & (MEM_READ | MEM_WRITE);
  assign illegal = (MEM_READ & MEM_WRITE)
                 | ~funct3_listed(FUNCT3)
                 | (MEM_WRITE & FUNCT3[2])          // BU/HU have no store form
                 | funct3_misaligned(FUNCT3, ALU_RESULT[1:0]);

  assign legal_access   = access & ~illegal;
  assign illegal_access = access & illegal;
  assign timeout        = (wait_cnt == CNT_LAST);

  // Byte enables and lane-replicated store data, chosen by the size bits.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = STORE_DATA;
    case (FUNCT3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << ALU_RESULT[1:0];
        wdata_next = {4{STORE_DATA[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << ALU_RESULT[1:0];
        wdata_next = {2{STORE_DATA[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = STORE_DATA;
      end
    endcase
  end

  load_align_ext u_load_align_ext (
    .rdata   (MEM_RDATA),
    .addr_lo (ctrl.addr_lo),
    .funct3  (ctrl.funct3),
    .result  (load_ext)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (legal_access) state_next = ST_WAIT;
      ST_WAIT: if (MEM_ACK || timeout) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Decoding from state lets reset drop REQ/BUSY/DONE at once.
  // --------------------------------------------------------------------------
  always_comb begin
    MEM_REQ = 1'b0;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    case (state)
      ST_IDLE: BUSY = legal_access;
      ST_WAIT: begin
        MEM_REQ = 1'b1;
        BUSY    = 1'b1;
      end
      ST_RESP: DONE = 1'b1;
      default: ;
    endcase
  end

  assign FAULT = fault_q;

  // --------------------------------------------------------------------------
  // Datapath: bus request latch, timeout counter, load result, fault pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= 32'h0;
      MEM_BE    <= 4'h0;
      MEM_WDATA <= 32'h0;
      LOAD_DATA <= 32'h0;
      wait_cnt  <= '0;
      fault_q   <= 1'b0;
      ctrl      <= '0;
    end else begin
      fault_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (legal_access) begin
            MEM_WE       <= MEM_WRITE;
            MEM_ADDR     <= {ALU_RESULT[31:2], 2'b00};
            MEM_BE       <= be_next;
            MEM_WDATA    <= wdata_next;
            ctrl.is_load <= MEM_READ;
            ctrl.funct3  <= FUNCT3;
            ctrl.addr_lo <= ALU_RESULT[1:0];
            wait_cnt     <= '0;
          end else if (illegal_access) begin
            fault_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          // An ack on the last allowed cycle still completes normally.
          if (MEM_ACK) begin
            if (ctrl.is_load) begin
              LOAD_DATA <= load_ext;
            end
          end else if (timeout) begin
            fault_q   <= 1'b1;
            LOAD_DATA <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit
//               (TIMEOUT_CYCLES = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        CLK;
  logic        RESETn;
  logic        VALID;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  FUNCT3;
  logic [31:0] ALU_RESULT;
  logic [31:0] STORE_DATA;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;
  logic        BUSY;
  logic        DONE;
  logic [31:0] LOAD_DATA;
  logic        FAULT;

  int checks   = 0;
  int failures = 0;

  mem_access_unit #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (5)
  ) dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .VALID      (VALID),
    .MEM_READ   (MEM_READ),
    .MEM_WRITE  (MEM_WRITE),
    .FUNCT3     (FUNCT3),
    .ALU_RESULT (ALU_RESULT),
    .STORE_DATA (STORE_DATA),
    .MEM_REQ    (MEM_REQ),
    .MEM_WE     (MEM_WE),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_BE     (MEM_BE),
    .MEM_WDATA  (MEM_WDATA),
    .MEM_RDATA  (MEM_RDATA),
    .MEM_ACK    (MEM_ACK),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .LOAD_DATA  (LOAD_DATA),
    .FAULT      (FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_req();
    VALID      = 1'b0;
    MEM_READ   = 1'b0;
    MEM_WRITE  = 1'b0;
    FUNCT3     = 3'b000;
    ALU_RESULT = 32'h0;
    STORE_DATA = 32'h0;
  endtask

  task automatic present(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd);
    VALID      = 1'b1;
    MEM_READ   = rd;
    MEM_WRITE  = wr;
    FUNCT3     = f3;
    ALU_RESULT = addr;
    STORE_DATA = sd;
  endtask

  // Legal access: accept cycle, `waits` WAIT cycles without ack, then an ack
  // cycle. Returns one step into the RESP cycle.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sd, input logic [31:0] rdata,
                            input int waits);
    present(rd, wr, f3, addr, sd);
    #1;
    check({tag, "_busy_accept"}, BUSY, 1);
    check({tag, "_req_accept"}, MEM_REQ, 0);
    next_cycle();
    clear_req();
    for (int i = 0; i < waits; i++) begin
      #1;
      check({tag, "_req_wait"}, MEM_REQ, 1);
      next_cycle();
    end
    MEM_ACK   = 1'b1;
    MEM_RDATA = rdata;
    #1;
    check({tag, "_req_ack"}, MEM_REQ, 1);
    check({tag, "_busy_ack"}, BUSY, 1);
    next_cycle();
    MEM_ACK   = 1'b0;
    MEM_RDATA = 32'h0;
    #1;
    check({tag, "_done"}, DONE, 1);
    check({tag, "_busy_resp"}, BUSY, 0);
    check({tag, "_req_resp"}, MEM_REQ, 0);
    check({tag, "_fault_resp"}, FAULT, 0);
  endtask

  // Illegal access: one FAULT pulse, no request, no stall, no DONE.
  task automatic run_illegal(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr);
    present(rd, wr, f3, addr, 32'h0);
    #1;
    check({tag, "_busy"}, BUSY, 0);
    next_cycle();
    clear_req();
    #1;
    check({tag, "_fault"}, FAULT, 1);
    check({tag, "_req"}, MEM_REQ, 0);
    check({tag, "_done"}, DONE, 0);
    next_cycle();
    check({tag, "_fault_clr"}, FAULT, 0);
    check({tag, "_req_after"}, MEM_REQ, 0);
  endtask

  initial begin
    RESETn    = 1'b0;
    MEM_ACK   = 1'b0;
    MEM_RDATA = 32'h0;
    clear_req();

    // Reset state
    next_cycle();
    next_cycle();
    check("rst_req", MEM_REQ, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_fault", FAULT, 0);
    check("rst_load", LOAD_DATA, 32'h0);
    check("rst_addr", MEM_ADDR, 32'h0);
    check("rst_be", MEM_BE, 4'h0);
    check("rst_wdata", MEM_WDATA, 32'h0);
    check("rst_we", MEM_WE, 0);
    RESETn = 1'b1;
    next_cycle();

    // LW at 0x100, zero-wait ack
    run_access("lw", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    check("lw_addr", MEM_ADDR, 32'h100);
    check("lw_be", MEM_BE, 4'b1111);
    check("lw_we", MEM_WE, 0);
    check("lw_data", LOAD_DATA, 32'hDEADBEEF);
    next_cycle();
    check("lw_done_clr", DONE, 0);

    // Sub-word loads of 0x80FF0000
    run_access("lb", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0);
    check("lb_be", MEM_BE, 4'b1000);
    check("lb_addr", MEM_ADDR, 32'h100);
    check("lb_data", LOAD_DATA, 32'hFFFFFF80);
    next_cycle();
    run_access("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0);
    check("lbu_data", LOAD_DATA, 32'h00000080);
    next_cycle();
    run_access("lh", 1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 0);
    check("lh_be", MEM_BE, 4'b1100);
    check("lh_data", LOAD_DATA, 32'hFFFF80FF);
    next_cycle();
    run_access("lhu", 1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF0000, 1);
    check("lhu_data", LOAD_DATA, 32'h000080FF);
    next_cycle();

    // SH at 0x202, REQ held 3 cycles, ack on the third
    run_access("sh", 0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 2);
    check("sh_addr", MEM_ADDR, 32'h200);
    check("sh_be", MEM_BE, 4'b1100);
    check("sh_wdata", MEM_WDATA, 32'hABCDABCD);
    check("sh_we", MEM_WE, 1);
    check("sh_load_kept", LOAD_DATA, 32'h000080FF);
    next_cycle();
    check("sh_addr_hold", MEM_ADDR, 32'h200);

    // SW: full word, no replication
    run_access("sw", 0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 0);
    check("sw_be", MEM_BE, 4'b1111);
    check("sw_wdata", MEM_WDATA, 32'hCAFEF00D);
    next_cycle();

    // Illegal accesses
    run_illegal("mis_lw", 1, 0, 3'b010, 32'h101);
    run_illegal("rd_wr", 1, 1, 3'b010, 32'h100);
    run_illegal("mis_lh", 1, 0, 3'b001, 32'h103);
    run_illegal("st_bu", 0, 1, 3'b100, 32'h100);
    run_illegal("f3_011", 1, 0, 3'b011, 32'h100);
    check("illegal_load_kept", LOAD_DATA, 32'h000080FF);

    // Timeout: REQ high for 4 cycles, then DONE and FAULT together
    present(1, 0, 3'b010, 32'h300, 32'h0);
    next_cycle();
    clear_req();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("to_req", MEM_REQ, 1);
      next_cycle();
    end
    #1;
    check("to_done", DONE, 1);
    check("to_fault", FAULT, 1);
    check("to_req_drop", MEM_REQ, 0);
    check("to_load", LOAD_DATA, 32'h0);
    MEM_ACK   = 1'b1;
    MEM_RDATA = 32'h12345678;
    next_cycle();
    MEM_ACK   = 1'b0;
    MEM_RDATA = 32'h0;
    check("late_ack_done", DONE, 0);
    check("late_ack_fault", FAULT, 0);
    check("late_ack_req", MEM_REQ, 0);
    check("late_ack_load", LOAD_DATA, 32'h0);
    next_cycle();

    // Load a known value, then reset during WAIT
    run_access("pre_rst", 1, 0, 3'b010, 32'h400, 32'h0, 32'h55AA55AA, 0);
    check("pre_rst_data", LOAD_DATA, 32'h55AA55AA);
    next_cycle();
    present(1, 0, 3'b010, 32'h404, 32'h0);
    next_cycle();
    clear_req();
    #1;
    check("rw_req_before", MEM_REQ, 1);
    #2;
    RESETn = 1'b0;
    #1;
    check("rw_req", MEM_REQ, 0);
    check("rw_busy", BUSY, 0);
    check("rw_done", DONE, 0);
    check("rw_fault", FAULT, 0);
    check("rw_load", LOAD_DATA, 32'h0);
    next_cycle();
    RESETn = 1'b1;
    next_cycle();
    check("rw_idle_req", MEM_REQ, 0);

    // SB at 0x001 after reset
    run_access("sb", 0, 1, 3'b000, 32'h001, 32'h000000A5, 32'h0, 0);
    check("sb_be", MEM_BE, 4'b0010);
    check("sb_wdata", MEM_WDATA, 32'hA5A5A5A5);
    check("sb_addr", MEM_ADDR, 32'h0);
    check("sb_we", MEM_WE, 1);
    next_cycle();
    check("sb_done_clr", DONE, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
